r88_stackseq: RTL and testbench
===============================

// Module: r88_stackseq
// PURPOSE
//  Push/pop sequencer for r88_regblock. On one start pulse it moves an 8- or 16-bit register to or from the stack.
//  It loads SP through intD, runs byte transfers on the memory handshake, and writes the updated SP back.
//  Sits beside the instruction decoder; owns regSel/regRead/regWrite while busy.
// PARAMETERS
//  TIMEOUT  15  max cycles to wait for memReady per byte before abort (1..255)
// PORTS
//  sysClock    in   1   system clock, all state changes on rising edge
//  sysResetN   in   1   asynchronous active-low reset
//  start       in   1   request strobe, sampled only in IDLE
//  opPop       in   1   0=push, 1=pop (sampled with start)
//  wide        in   1   1=16-bit pair transfer (sampled with start)
//  srcSel      in   4   regblock code of register / low byte of pair
//  intDIn      in   8   internal bus as seen by this block
//  intDOut     out  8   data this block drives onto intD
//  intDOutEn   out  1   enable for intDOut tri-state at top level
//  regSel      out  4   regblock register select
//  regRead     out  1   regblock read strobe
//  regWrite    out  1   regblock write strobe
//  memAddr     out  16  stack byte address
//  memRead     out  1   memory read request, held until memReady
//  memWrite    out  1   memory write request, held until memReady; data = intDIn
//  memDataIn   in   8   memory read data, valid when memReady & memRead
//  memReady    in   1   memory completes current request this cycle
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle pulse on successful completion
//  err         out  1   one-cycle pulse on reject or timeout
// BEHAVIOUR
//  Reset
//  - Async on sysResetN low. State=IDLE; all outputs 0; pointer=0000.
//  - Mid-operation reset abandons the transfer; SP is not written back.
//  Start and reject
//  - start in IDLE latches opPop, wide, srcSel. start while busy is ignored.
//  - Reject: wide & srcSel not in {3,5,7}; srcSel in {9,10} (SP); srcSel>11; opPop & srcSel==11.
//  - A rejected start pulses err in the next cycle and stays in IDLE, with no strobes.
//  Register reads
//  - A regblock read takes 2 cycles: cycle 1 asserts regRead+regSel; cycle 2 holds both and samples intDIn.
//  States
//  - LDSP: read SP lo (sel 9) then SP hi (sel 10), 4 cycles, into a 16-bit pointer.
//  - PUSH: pre-decrement pointer (mod 2^16).
//    - PUSH_RD: read byte (2 cycles).
//    - PUSH_WR: memAddr=pointer, memWrite=1 until memReady; regRead+regSel held so intD carries data.
//    - Wide: high byte (srcSel+1) first at SP-1, then low at SP-2, giving a little-endian image.
//  - POP: memAddr=pointer, memRead=1 until memReady.
//    - Latch memDataIn, then POP_WR (1 cycle): intDOutEn=1, regWrite=1, regSel=target.
//    - Then pointer+1. Wide: low byte to srcSel first, then high to srcSel+1.
//  - WBSP: write pointer lo (sel 9) then hi (sel 10), 1 cycle each, intDOutEn=1.
//  - DONE: done=1 for 1 cycle, then IDLE.
//  Timing (memReady already high)
//  - Start sampled at edge k; done is high in cycle k+10 for push8, k+13 push16, k+9 pop8, k+11 pop16.
//  - Each wait cycle on memReady adds 1.
//  Timeout
//  - Wait counter resets per byte. After TIMEOUT cycles without memReady: drop request, err=1 one cycle, IDLE.
//  - On timeout SP is not written back; the register may be partly updated.
//  Exclusivity and wrap
//  - Never regRead and regWrite together; never memRead and memWrite together.
//  - intDOutEn only in POP_WR/WBSP.
//  - Wrap: push with SP=0000 writes FFFF; pop with SP=FFFF reads FFFF, SP becomes 0000.
// TESTING
//  1. SP=FFF9, A=5A, push8 sel0 -> mem[FFF8]=5A, SP=FFF8, done at k+10.
//  2. SP=FFF9, DD=1234, push16 sel3 -> mem[FFF8]=12, mem[FFF7]=34, SP=FFF7, done at k+13.
//  3. SP=FFF7 (image 34,12), pop16 sel5 -> EE=1234, SP=FFF9.
//  4. memReady held low, TIMEOUT=15 -> err at 15th wait cycle, SP unchanged.
//  5. Reject: push16 sel0 or pop sel11 -> err next cycle, no strobes. SP=0000 push8 -> mem[FFFF], SP=FFFF.
//  6. start during busy ignored; sysResetN low mid-PUSH_WR -> outputs 0 at once, SP unchanged.

Source files
------------

// File: rtl/r88_stackseq.sv
// r88_stackseq: push/pop sequencer beside r88_regblock.
// One accepted start moves an 8-bit register or a 16-bit pair between the
// regblock and the stack. SP is read through intD, bytes move over the
// memory handshake, and the updated SP is written back on success.
module r88_stackseq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        sysClock,
  input  logic        sysResetN,
  input  logic        start,
  input  logic        opPop,
  input  logic        wide,
  input  logic [3:0]  srcSel,
  input  logic [7:0]  intDIn,
  output logic [7:0]  intDOut,
  output logic        intDOutEn,
  output logic [3:0]  regSel,
  output logic        regRead,
  output logic        regWrite,
  output logic [15:0] memAddr,
  output logic        memRead,
  output logic        memWrite,
  input  logic [7:0]  memDataIn,
  input  logic        memReady,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LDSP_L1 = 4'd1;
  localparam logic [3:0] S_LDSP_L2 = 4'd2;
  localparam logic [3:0] S_LDSP_H1 = 4'd3;
  localparam logic [3:0] S_LDSP_H2 = 4'd4;
  localparam logic [3:0] S_PUSH_R1 = 4'd5;
  localparam logic [3:0] S_PUSH_R2 = 4'd6;
  localparam logic [3:0] S_PUSH_WR = 4'd7;
  localparam logic [3:0] S_POP_MEM = 4'd8;
  localparam logic [3:0] S_POP_WR  = 4'd9;
  localparam logic [3:0] S_WBSP_L  = 4'd10;
  localparam logic [3:0] S_WBSP_H  = 4'd11;
  localparam logic [3:0] S_DONE    = 4'd12;

  localparam logic [3:0] SEL_SPL = 4'd9;
  localparam logic [3:0] SEL_SPH = 4'd10;

  // Last permitted wait count: abort when this many waits have already elapsed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [3:0]  state;
  logic        op_pop;
  logic        is_wide;
  logic [3:0]  sel;
  logic        second;
  logic [15:0] ptr;
  logic [7:0]  data;
  logic [7:0]  wcnt;
  logic        err_q;
  logic        reject;
  logic [3:0]  t_sel;

  // Illegal request decode: bad pair base, SP itself, unknown codes, pop to 11.
  always_comb begin
    reject = 1'b0;
    if (wide && !(srcSel == 4'd3 || srcSel == 4'd5 || srcSel == 4'd7)) reject = 1'b1;
    if (srcSel == SEL_SPL || srcSel == SEL_SPH) reject = 1'b1;
    if (srcSel > 4'd11) reject = 1'b1;
    if (opPop && srcSel == 4'd11) reject = 1'b1;
  end

  // Current byte target: push takes the high half first, pop the low half first.
  always_comb begin
    t_sel = sel;
    if (is_wide && (op_pop ? second : !second)) t_sel = sel + 4'd1;
  end

  // Strobes and bus drive decoded purely from state so reset clears them at once.
  always_comb begin
    intDOut   = '0;
    intDOutEn = 1'b0;
    regSel    = '0;
    regRead   = 1'b0;
    regWrite  = 1'b0;
    memAddr   = '0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    err       = err_q;
    case (state)
      S_LDSP_L1, S_LDSP_L2: begin
        regSel  = SEL_SPL;
        regRead = 1'b1;
      end
      S_LDSP_H1, S_LDSP_H2: begin
        regSel  = SEL_SPH;
        regRead = 1'b1;
      end
      S_PUSH_R1, S_PUSH_R2: begin
        regSel  = t_sel;
        regRead = 1'b1;
      end
      S_PUSH_WR: begin
        regSel   = t_sel;
        regRead  = 1'b1;
        memAddr  = ptr;
        memWrite = 1'b1;
      end
      S_POP_MEM: begin
        memAddr = ptr;
        memRead = 1'b1;
      end
      S_POP_WR: begin
        regSel    = t_sel;
        regWrite  = 1'b1;
        intDOutEn = 1'b1;
        intDOut   = data;
      end
      S_WBSP_L: begin
        regSel    = SEL_SPL;
        regWrite  = 1'b1;
        intDOutEn = 1'b1;
        intDOut   = ptr[7:0];
      end
      S_WBSP_H: begin
        regSel    = SEL_SPH;
        regWrite  = 1'b1;
        intDOutEn = 1'b1;
        intDOut   = ptr[15:8];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, pointer arithmetic and per-byte wait/timeout tracking.
  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state   <= S_IDLE;
      op_pop  <= 1'b0;
      is_wide <= 1'b0;
      sel     <= '0;
      second  <= 1'b0;
      ptr     <= '0;
      data    <= '0;
      wcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      wcnt  <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              op_pop  <= opPop;
              is_wide <= wide;
              sel     <= srcSel;
              second  <= 1'b0;
              state   <= S_LDSP_L1;
            end
          end
        end
        S_LDSP_L1: state <= S_LDSP_L2;
        S_LDSP_L2: begin
          ptr[7:0] <= intDIn;
          state    <= S_LDSP_H1;
        end
        S_LDSP_H1: state <= S_LDSP_H2;
        // Push pre-decrement is folded into the SP-high sample to save a cycle.
        S_LDSP_H2: begin
          if (op_pop) begin
            ptr   <= {intDIn, ptr[7:0]};
            state <= S_POP_MEM;
          end else begin
            ptr   <= {intDIn, ptr[7:0]} - 16'd1;
            state <= S_PUSH_R1;
          end
        end
        S_PUSH_R1: state <= S_PUSH_R2;
        S_PUSH_R2: begin
          data  <= intDIn;
          state <= S_PUSH_WR;
        end
        S_PUSH_WR: begin
          if (memReady) begin
            if (is_wide && !second) begin
              second <= 1'b1;
              ptr    <= ptr - 16'd1;
              state  <= S_PUSH_R1;
            end else begin
              state <= S_WBSP_L;
            end
          end else if (wcnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_POP_MEM: begin
          if (memReady) begin
            data  <= memDataIn;
            ptr   <= ptr + 16'd1;
            state <= S_POP_WR;
          end else if (wcnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_POP_WR: begin
          if (is_wide && !second) begin
            second <= 1'b1;
            state  <= S_POP_MEM;
          end else begin
            state <= S_WBSP_L;
          end
        end
        S_WBSP_L: state <= S_WBSP_H;
        S_WBSP_H: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r88_stackseq.sv
// Bench for r88_stackseq: regblock/memory model around the DUT, directed
// operations push expected completions into a scoreboard, a monitor pops
// and checks them whenever done or err appears.
module tb_r88_stackseq;

  logic        sysClock;
  logic        sysResetN;
  logic        start;
  logic        opPop;
  logic        wide;
  logic [3:0]  srcSel;
  logic [7:0]  intDIn;
  logic [7:0]  intDOut;
  logic        intDOutEn;
  logic [3:0]  regSel;
  logic        regRead;
  logic        regWrite;
  logic [15:0] memAddr;
  logic        memRead;
  logic        memWrite;
  logic [7:0]  memDataIn;
  logic        memReady;
  logic        busy;
  logic        done;
  logic        err;

  r88_stackseq #(.TIMEOUT(15)) dut (
    .sysClock(sysClock), .sysResetN(sysResetN), .start(start), .opPop(opPop),
    .wide(wide), .srcSel(srcSel), .intDIn(intDIn), .intDOut(intDOut),
    .intDOutEn(intDOutEn), .regSel(regSel), .regRead(regRead), .regWrite(regWrite),
    .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite), .memDataIn(memDataIn),
    .memReady(memReady), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    bit          is_err;
    int          start_cyc;
    int          lat;
    logic [15:0] sp;
    int          nm;
    logic [15:0] ma0, ma1;
    logic [7:0]  mv0, mv1;
    int          nr;
    logic [3:0]  rs0, rs1;
    logic [7:0]  rv0, rv1;
  } exp_t;

  exp_t q[$];

  logic [7:0]  regs [0:15];
  logic [7:0]  mem  [0:65535];
  int          cyc = 0;
  int          wc = 0;
  int          stall_n = 0;
  int          checks = 0;
  int          errors = 0;
  logic        pl_en = 1'b0;
  logic        pl_mem = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_val = '0;

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  always @(posedge sysClock) cyc <= cyc + 1;

  // Shared intD bus and memory read data.
  always_comb begin
    intDIn = 8'h00;
    if (intDOutEn) intDIn = intDOut;
    else if (regRead) intDIn = regs[regSel];
    memDataIn = 8'h00;
    if (memRead) memDataIn = mem[memAddr];
    memReady = (memRead || memWrite) && (wc >= stall_n);
  end

  // Regblock/memory state updates and wait counter, single owner.
  always @(posedge sysClock) begin
    if (pl_en) begin
      if (pl_mem) mem[pl_addr] <= pl_val;
      else regs[pl_addr[3:0]] <= pl_val;
    end else if (sysResetN) begin
      if (regWrite) regs[regSel] <= intDIn;
      if (memWrite && memReady) mem[memAddr] <= intDIn;
    end
    if ((memRead || memWrite) && !memReady) wc <= wc + 1;
    else wc <= 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every completion and checks invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysClock);
      if (sysResetN) begin
        if (busy)
          chk("exclusive", 32'({regRead & regWrite, memRead & memWrite, intDOutEn ^ regWrite}), 32'd0);
        if (done || err) begin
          chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("kind", 32'({done, err}), 32'({~e.is_err, e.is_err}));
            chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            chk("sp", 32'({regs[10], regs[9]}), 32'(e.sp));
            if (e.nm > 0) chk("mem0", 32'(mem[e.ma0]), 32'(e.mv0));
            if (e.nm > 1) chk("mem1", 32'(mem[e.ma1]), 32'(e.mv1));
            if (e.nr > 0) chk("reg0", 32'(regs[e.rs0]), 32'(e.rv0));
            if (e.nr > 1) chk("reg1", 32'(regs[e.rs1]), 32'(e.rv1));
          end
          if (err)
            chk("err_quiet", 32'({busy, regRead, regWrite, memRead, memWrite, intDOutEn}), 32'd0);
        end
      end
    end
  end

  function automatic exp_t mk(input bit is_err, input int lat, input logic [15:0] sp);
    exp_t e;
    e = '{default: '0};
    e.is_err = is_err;
    e.lat    = lat;
    e.sp     = sp;
    return e;
  endfunction

  task automatic preload(input bit is_mem, input logic [15:0] addr, input logic [7:0] val);
    pl_mem  = is_mem;
    pl_addr = addr;
    pl_val  = val;
    pl_en   = 1'b1;
    @(negedge sysClock);
    pl_en   = 1'b0;
  endtask

  task automatic set_sp(input logic [15:0] sp);
    preload(1'b0, 16'd9, sp[7:0]);
    preload(1'b0, 16'd10, sp[15:8]);
  endtask

  task automatic go(input bit pop, input bit wd, input logic [3:0] s, input exp_t e);
    exp_t x;
    x = e;
    opPop  = pop;
    wide   = wd;
    srcSel = s;
    start  = 1'b1;
    x.start_cyc = cyc;
    q.push_back(x);
    @(negedge sysClock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !busy) break;
      @(negedge sysClock);
    end
    chk("drained", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge sysClock);
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, 32'({busy, done, err, regRead, regWrite, memRead, memWrite, intDOutEn, regSel}), 32'd0);
    chk(tag, 32'({memAddr, intDOut}), 32'd0);
  endtask

  logic [5:0] rej_tab [0:6];

  initial begin
    exp_t e;
    bit seen;
    start = 1'b0; opPop = 1'b0; wide = 1'b0; srcSel = '0;
    sysResetN = 1'b0;
    rej_tab[0] = {1'b0, 1'b1, 4'd0};
    rej_tab[1] = {1'b1, 1'b0, 4'd11};
    rej_tab[2] = {1'b0, 1'b0, 4'd9};
    rej_tab[3] = {1'b0, 1'b0, 4'd10};
    rej_tab[4] = {1'b0, 1'b0, 4'd12};
    rej_tab[5] = {1'b0, 1'b1, 4'd4};
    rej_tab[6] = {1'b1, 1'b1, 4'd11};
    repeat (3) @(negedge sysClock);
    check_quiet("reset_state");
    sysResetN = 1'b1;
    @(negedge sysClock);

    set_sp(16'hFFF9);
    preload(1'b0, 16'd0, 8'h5A);
    preload(1'b0, 16'd3, 8'h34);
    preload(1'b0, 16'd4, 8'h12);
    preload(1'b0, 16'd11, 8'h3C);

    // push8 A
    e = mk(1'b0, 10, 16'hFFF8); e.nm = 1; e.ma0 = 16'hFFF8; e.mv0 = 8'h5A;
    go(1'b0, 1'b0, 4'd0, e); wait_idle();

    // push16 DD
    set_sp(16'hFFF9);
    e = mk(1'b0, 13, 16'hFFF7); e.nm = 2;
    e.ma0 = 16'hFFF8; e.mv0 = 8'h12; e.ma1 = 16'hFFF7; e.mv1 = 8'h34;
    go(1'b0, 1'b1, 4'd3, e); wait_idle();

    // pop16 into EE
    e = mk(1'b0, 11, 16'hFFF9); e.nr = 2;
    e.rs0 = 4'd5; e.rv0 = 8'h34; e.rs1 = 4'd6; e.rv1 = 8'h12;
    go(1'b1, 1'b1, 4'd5, e); wait_idle();

    // pop8 with 2 wait cycles
    preload(1'b1, 16'hFFF9, 8'hA7);
    stall_n = 2;
    e = mk(1'b0, 11, 16'hFFFA); e.nr = 1; e.rs0 = 4'd1; e.rv0 = 8'hA7;
    go(1'b1, 1'b0, 4'd1, e); wait_idle();
    stall_n = 0;

    // rejected requests
    for (int i = 0; i < 7; i++) begin
      e = mk(1'b1, 1, 16'hFFFA);
      go(rej_tab[i][5], rej_tab[i][4], rej_tab[i][3:0], e);
      wait_idle();
    end

    // push8 from code 11 is legal
    e = mk(1'b0, 10, 16'hFFF9); e.nm = 1; e.ma0 = 16'hFFF9; e.mv0 = 8'h3C;
    go(1'b0, 1'b0, 4'd11, e); wait_idle();

    // wrap: push with SP=0000, pop with SP=FFFF
    set_sp(16'h0000);
    preload(1'b0, 16'd2, 8'hC3);
    e = mk(1'b0, 10, 16'hFFFF); e.nm = 1; e.ma0 = 16'hFFFF; e.mv0 = 8'hC3;
    go(1'b0, 1'b0, 4'd2, e); wait_idle();
    e = mk(1'b0, 9, 16'h0000); e.nr = 1; e.rs0 = 4'd7; e.rv0 = 8'hC3;
    go(1'b1, 1'b0, 4'd7, e); wait_idle();

    // push16 across wrap with 3 waits per byte
    preload(1'b0, 16'd8, 8'h9E);
    stall_n = 3;
    e = mk(1'b0, 19, 16'hFFFE); e.nm = 2;
    e.ma0 = 16'hFFFF; e.mv0 = 8'h9E; e.ma1 = 16'hFFFE; e.mv1 = 8'hC3;
    go(1'b0, 1'b1, 4'd7, e); wait_idle();

    // timeout boundary: 14 waits succeed, 15 abort
    stall_n = 14;
    e = mk(1'b0, 24, 16'hFFFD); e.nm = 1; e.ma0 = 16'hFFFD; e.mv0 = 8'h5A;
    go(1'b0, 1'b0, 4'd0, e); wait_idle();
    preload(1'b1, 16'hFFFC, 8'h00);
    stall_n = 15;
    e = mk(1'b1, 22, 16'hFFFD); e.nm = 1; e.ma0 = 16'hFFFC; e.mv0 = 8'h00;
    go(1'b0, 1'b0, 4'd0, e); wait_idle();
    stall_n = 0;

    // start while busy is ignored
    e = mk(1'b0, 10, 16'hFFFC); e.nm = 1; e.ma0 = 16'hFFFC; e.mv0 = 8'h5A;
    go(1'b0, 1'b0, 4'd0, e);
    repeat (2) @(negedge sysClock);
    opPop = 1'b1; wide = 1'b0; srcSel = 4'd11; start = 1'b1;
    @(negedge sysClock);
    start = 1'b0;
    wait_idle();

    // reset during PUSH_WR
    stall_n = 100;
    opPop = 1'b0; wide = 1'b0; srcSel = 4'd0; start = 1'b1;
    @(negedge sysClock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (memWrite) begin
        seen = 1'b1;
        break;
      end
      @(negedge sysClock);
    end
    chk("reached_push_wr", 32'(seen), 32'd1);
    sysResetN = 1'b0;
    #1;
    check_quiet("mid_reset");
    chk("mid_reset_sp", 32'({regs[10], regs[9]}), 32'h0000FFFC);
    @(negedge sysClock);
    sysResetN = 1'b1;
    stall_n = 0;
    @(negedge sysClock);

    // recovery: pop what the earlier push left at FFFC
    e = mk(1'b0, 9, 16'hFFFD); e.nr = 1; e.rs0 = 4'd1; e.rv0 = 8'h5A;
    go(1'b1, 1'b0, 4'd1, e); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
